// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch
// requester and the data (load/store) requester. Data has priority, and
// fetch is guaranteed a grant after STARVE_MAX consecutive data grants.
// Read responses return one cycle after issue and are routed to their owner,
// with a per-port hold register keeping read data stable across stalls.
// Optional wait-cycle performance counters: define MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_stall,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_e            owner_q, owner_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;
  logic              fetch_forced;

  // Fetch overrides data priority once it has waited STARVE_MAX data grants
  assign fetch_forced = if_req && (starve_q == STARVE_LIM);

  // Per-cycle arbitration and RAM drive; everything is held off during reset
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_be    = 4'b0000;
    if (!rst) begin
      if (d_req && !fetch_forced) begin
        d_gnt    = 1'b1;
        ram_en   = 1'b1;
        ram_addr = d_addr;
        if (d_we) begin
          ram_we    = 1'b1;
          ram_wdata = d_wdata;
          ram_be    = d_be;
        end
      end else if (if_req) begin
        if_gnt   = 1'b1;
        ram_en   = 1'b1;
        ram_addr = if_addr;
      end
    end
  end

  assign if_stall = if_req & ~if_gnt & ~rst;
  assign d_stall  = d_req & ~d_gnt & ~rst;

  // Responses: rvalid follows the owner recorded at issue, data bypasses hold
  assign if_rvalid = (owner_q == OWN_IF);
  assign d_rvalid  = (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? ram_rdata : if_hold_q;
  assign d_rdata   = d_rvalid ? ram_rdata : d_hold_q;

  // Next-state: response owner, starvation count and per-port hold capture
  always_comb begin
    owner_d   = OWN_NONE;
    starve_d  = starve_q;
    if_hold_d = if_hold_q;
    d_hold_d  = d_hold_q;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
    if (if_gnt || !if_req) begin
      starve_d = 4'd0;
    end else if (d_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
    if (owner_q == OWN_IF) begin
      if_hold_d = ram_rdata;
    end
    if (owner_q == OWN_D) begin
      d_hold_d = ram_rdata;
    end
  end

  // State registers; reset discards any outstanding read
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      starve_q  <= 4'd0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      if_hold_q <= if_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_d_q, perf_d_d;

  // Wait-cycle counters advance on every stalled cycle and wrap around
  always_comb begin
    perf_if_d = perf_if_q;
    perf_d_d  = perf_d_q;
    if (if_stall) perf_if_d = perf_if_q + 32'd1;
    if (d_stall)  perf_d_d  = perf_d_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_q <= 32'd0;
      perf_d_q  <= 32'd0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_d_q  <= perf_d_d;
    end
  end

  assign perf_if_wait = perf_if_q;
  assign perf_d_wait  = perf_d_q;
`else
  assign perf_if_wait = 32'd0;
  assign perf_d_wait  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// byte-enabled single-port RAM (one-cycle read latency) attached.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_stall, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt, d_stall, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [31:0]       perf_if_wait, perf_d_wait;

  logic [DATA_W-1:0] mem [0:127];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata),
    .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: byte-enabled write, registered read
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[8:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[8:2]];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = 4'b0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_if_rvalid got %b want 0", if_rvalid); end
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_rvalid got %b want 0", d_rvalid); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_if_rdata got %h want 0", if_rdata); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_d_rdata got %h want 0", d_rdata); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_en got %b want 0", ram_en); end
    checks++; if (perf_if_wait !== 32'd0) begin errors++; $display("[TB] FAIL reset_perf_if got %0d want 0", perf_if_wait); end
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 9'h004;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("[TB] FAIL fetch_gnt got %b want 1", if_gnt); end
    checks++; if (if_stall !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall got %b want 0", if_stall); end
    checks++; if (ram_en !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ram_en got %b want 1", ram_en); end
    checks++; if (ram_addr !== 9'h004) begin errors++; $display("[TB] FAIL fetch_ram_addr got %h want 004", ram_addr); end
    checks++; if (ram_we !== 1'b0 || ram_be !== 4'b0000) begin errors++; $display("[TB] FAIL fetch_ram_we_be got %b/%b want 0/0000", ram_we, ram_be); end
    step();
    if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_rvalid got %b want 1", if_rvalid); end
    checks++; if (if_rdata !== 32'h00500093) begin errors++; $display("[TB] FAIL fetch_rdata got %h want 00500093", if_rdata); end
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_d_rvalid got %b want 0", d_rvalid); end
    step();
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_rvalid_after got %b want 0", if_rvalid); end
    checks++; if (if_rdata !== 32'h00500093) begin errors++; $display("[TB] FAIL fetch_hold got %h want 00500093", if_rdata); end
  endtask

  task automatic test_conflict();
    do_reset();
    if_req = 1'b1; if_addr = 9'h00C;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("[TB] FAIL conflict_dgnt_%0d got d=%b if=%b want d=1 if=0", i, d_gnt, if_gnt); end
      checks++; if (if_stall !== 1'b1 || d_stall !== 1'b0) begin errors++; $display("[TB] FAIL conflict_stall_%0d got if=%b d=%b want if=1 d=0", i, if_stall, d_stall); end
      checks++; if (d_rvalid !== (i != 0)) begin errors++; $display("[TB] FAIL conflict_drvalid_%0d got %b want %b", i, d_rvalid, (i != 0)); end
      step();
    end
    #1;
    checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("[TB] FAIL conflict_starve_gnt got if=%b d=%b want if=1 d=0", if_gnt, d_gnt); end
    checks++; if (d_stall !== 1'b1 || ram_addr !== 9'h00C) begin errors++; $display("[TB] FAIL conflict_starve_addr got stall=%b addr=%h want 1/00C", d_stall, ram_addr); end
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h11110010) begin errors++; $display("[TB] FAIL conflict_load got %b/%h want 1/11110010", d_rvalid, d_rdata); end
    step();
    if_req = 1'b0;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("[TB] FAIL conflict_d_after got %b want 1", d_gnt); end
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFE0003) begin errors++; $display("[TB] FAIL conflict_fetch_data got %b/%h want 1/CAFE0003", if_rvalid, if_rdata); end
    checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h11110010) begin errors++; $display("[TB] FAIL conflict_d_hold got %b/%h want 0/11110010", d_rvalid, d_rdata); end
    step();
    d_req = 1'b0;
    checks++; if (d_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL conflict_last_drvalid got %b want 1", d_rvalid); end
`ifdef MEM_PORT_ARBITER_PERF_EN
    checks++; if (perf_if_wait !== 32'd3) begin errors++; $display("[TB] FAIL perf_if_wait got %0d want 3", perf_if_wait); end
    checks++; if (perf_d_wait !== 32'd1) begin errors++; $display("[TB] FAIL perf_d_wait got %0d want 1", perf_d_wait); end
`else
    checks++; if (perf_if_wait !== 32'd0) begin errors++; $display("[TB] FAIL perf_if_wait got %0d want 0", perf_if_wait); end
    checks++; if (perf_d_wait !== 32'd0) begin errors++; $display("[TB] FAIL perf_d_wait got %0d want 0", perf_d_wait); end
`endif
    step();
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h008; d_wdata = 32'hDEADBEEF; d_be = 4'b1111;
    #1;
    checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("[TB] FAIL store_issue got gnt=%b we=%b want 1/1", d_gnt, ram_we); end
    checks++; if (ram_wdata !== 32'hDEADBEEF || ram_be !== 4'b1111 || ram_addr !== 9'h008) begin errors++; $display("[TB] FAIL store_bus got %h/%b/%h want DEADBEEF/1111/008", ram_wdata, ram_be, ram_addr); end
    step();
    d_we = 1'b0; d_wdata = '0; d_be = 4'b0000;
    #1;
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL store_no_rvalid got %b want 0", d_rvalid); end
    checks++; if (ram_we !== 1'b0 || ram_be !== 4'b0000 || ram_en !== 1'b1) begin errors++; $display("[TB] FAIL load_issue got we=%b be=%b en=%b want 0/0000/1", ram_we, ram_be, ram_en); end
    step();
    d_req = 1'b0;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_after_store got %b/%h want 1/DEADBEEF", d_rvalid, d_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    d_req = 1'b1; d_addr = 9'h020;
    step();
    d_req = 1'b0; if_req = 1'b1; if_addr = 9'h00C;
    #1;
    checks++; if (ram_en !== 1'b1 || ram_addr !== 9'h00C) begin errors++; $display("[TB] FAIL b2b_if_issue got %b/%h want 1/00C", ram_en, ram_addr); end
    checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_rdata !== 32'h22220020) begin errors++; $display("[TB] FAIL b2b_d_resp got %b/%b/%h want 1/0/22220020", d_rvalid, if_rvalid, d_rdata); end
    step();
    if_req = 1'b0; d_req = 1'b1; d_addr = 9'h020;
    #1;
    checks++; if (ram_en !== 1'b1 || ram_addr !== 9'h020) begin errors++; $display("[TB] FAIL b2b_d_issue got %b/%h want 1/020", ram_en, ram_addr); end
    checks++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'hCAFE0003) begin errors++; $display("[TB] FAIL b2b_if_resp got %b/%b/%h want 1/0/CAFE0003", if_rvalid, d_rvalid, if_rdata); end
    checks++; if (d_rdata !== 32'h22220020) begin errors++; $display("[TB] FAIL b2b_d_hold got %h want 22220020", d_rdata); end
    step();
    d_req = 1'b0;
    checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_last got d=%b if=%b want 1/0", d_rvalid, if_rvalid); end
    checks++; if (if_rdata !== 32'hCAFE0003) begin errors++; $display("[TB] FAIL b2b_if_hold got %h want CAFE0003", if_rdata); end
    step();
  endtask

  task automatic test_reset_mid_read();
    if_req = 1'b1; if_addr = 9'h004;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("[TB] FAIL midrst_gnt got %b want 1", if_gnt); end
    rst = 1'b1; d_req = 1'b1; d_addr = 9'h010;
    #1;
    checks++; if (if_stall !== 1'b0 || d_stall !== 1'b0 || if_gnt !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_forced got %b%b%b%b want 0000", if_stall, d_stall, if_gnt, ram_en); end
    step();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL midrst_discard got %b/%h want 0/0", if_rvalid, if_rdata); end
    step();
    checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after got %b/%b want 0/0", if_rvalid, d_rvalid); end
    // Prime the starvation counter to 2, reset, and confirm it restarts at 0
    if_req = 1'b1; if_addr = 9'h00C; d_req = 1'b1; d_addr = 9'h010;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("[TB] FAIL starve_clr_0 got %b want 1", d_gnt); end
    step();
    checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("[TB] FAIL starve_clr_1 got d=%b if=%b want 1/0", d_gnt, if_gnt); end
    idle_inputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[1] = 32'h00500093;
    mem[3] = 32'hCAFE0003;
    mem[4] = 32'h11110010;
    mem[8] = 32'h22220020;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_fetch_only();
    test_conflict();
    test_store_load();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch requester and the data-memory (load/store) requester of the 5-stage pipeline.
- Arbitrates per cycle, with data priority and an anti-starvation limit for fetch.
- Drives the RAM control signals and routes each 1-cycle-latency read response back to its owner.
- Produces the stall levels the pipeline uses for its PC halt and IF_ID write enable.

Parameters:
- ADDR_W, 9, RAM byte-address width.
- DATA_W, 32, data width.
- STARVE_MAX, 3, maximum consecutive data grants while fetch waits. Legal range is 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch issued this cycle.
- if_stall  out  1  if_req & ~if_gnt.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  data access issued this cycle.
- d_stall  out  1  d_req & ~d_gnt.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_be  out  4  RAM byte enables.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read issue.
- perf_if_wait  out  32  fetch wait-cycle count (optional feature).
- perf_d_wait  out  32  data wait-cycle count (optional feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Arbitration (combinational each cycle):
  - If d_req and not (if_req and starve_cnt==STARVE_MAX): grant data.
  - Else if if_req: grant fetch.
  - Else: no grant.
  - At most one grant per cycle.
- Issue cycle:
  - ram_en=1 and ram_addr = granted address.
  - Data store: ram_we=1, ram_wdata=d_wdata, ram_be=d_be.
  - Any read: ram_we=0, ram_be=4'b0000.
  - No grant: ram_en=0, ram_we=0, ram_be=0; ram_addr and ram_wdata are don't-care (drive 0).
- Pipelining: the response register `owner` ∈ {NONE, IF, D} is set at the issue cycle to the owner of the read, or NONE for a store or no grant.
  - Next cycle: if_rvalid = (owner==IF); d_rvalid = (owner==D).
  - A new access may issue in the same cycle a response returns, giving back-to-back 1 access/cycle.
  - Stores complete at grant; they produce no rvalid.
- Read data:
  - Per-port hold register captures ram_rdata when that port's rvalid=1.
  - x_rdata = x_rvalid ? ram_rdata : hold, so data stays stable while the pipeline is stalled.
  - Each hold register is written only by its own port's responses.
- Starvation counter starve_cnt (4 bits):
  - +1 on each cycle with d_gnt & if_req, saturating at STARVE_MAX.
  - Cleared on if_gnt or when if_req=0.
  - When starve_cnt==STARVE_MAX and if_req, fetch wins the next arbitration even if d_req=1.
- Reset values (rst=1 at a clk edge):
  - owner=NONE, starve_cnt=0, hold registers=0, perf counters=0.
  - All rvalid=0 and rdata=0 after reset.
  - Grants, stalls and RAM strobes are combinational and follow requests; during rst=1 they are forced to 0, so stalls are 0 while in reset.
- Reset mid-operation: an outstanding read is discarded. No rvalid is produced in the cycle after reset releases, even if ram_rdata changes.
- Requester contract: the requester holds req/addr/wdata stable until its grant. A request dropped before its grant is simply not issued; no error is raised.
- Simultaneous events:
  - Both requests with starve_cnt<STARVE_MAX: data granted, if_stall=1.
  - Same-address store followed by a fetch read: the store is issued first; the fetch sees the new data.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- When defined:
  - perf_if_wait increments on each cycle with if_stall=1.
  - perf_d_wait increments on each cycle with d_stall=1.
  - Both are 32-bit wrap-around counters, cleared by rst.
- When undefined: both ports are tied to 32'd0 and no counter flops exist.

Test Plan:
1. Reset then fetch only: if_req=1, if_addr=0x004 for 1 cycle, ram_rdata=0x00500093 next cycle -> if_gnt=1, ram_en=1, ram_addr=0x004; next cycle if_rvalid=1, if_rdata=0x00500093; afterward if_rdata holds 0x00500093 with if_rvalid=0.
2. Conflict: if_req and d_req (load, d_addr=0x010) held continuously, STARVE_MAX=3 -> d_gnt for 3 cycles with if_stall=1, 4th cycle if_gnt=1, starve_cnt back to 0; d_rvalid only after d grants.
3. Store then load: d_we=1, d_addr=0x008, d_wdata=0xDEADBEEF, d_be=4'b1111, then load 0x008 -> ram_we=1 for one cycle with no d_rvalid; next load gives d_rvalid=1 with RAM data 0xDEADBEEF.
4. Back-to-back reads alternating d (addr 0x020) and if (addr 0x00C) -> one ram_en per cycle; rvalid alternates with the correct owner each cycle; neither hold register is corrupted by the other port's response.
5. Reset mid-read: fetch granted, rst=1 on the next edge -> if_rvalid=0, if_rdata=0, all stalls=0 during reset, starve_cnt=0.
6. With MEM_PORT_ARBITER_PERF_EN: run scenario 2 -> perf_if_wait=3 and perf_d_wait equals the data stall cycles; without the macro both stay 0.
